// File: rtl/ledr_seq_pkg.sv
// ledr_seq_pkg: shared types, register map and CTRL field positions for the LEDR sequencer.
package ledr_seq_pkg;
   typedef enum logic [1:0] {ROTL = 2'd0, BOUNCE = 2'd1, COUNT = 2'd2, BLINK = 2'd3} mode_t;
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_PERIOD = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;
   localparam int CTRL_RUN     = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/ledr_pattern_step.sv
// ledr_pattern_step: combinational next-pattern / next-direction for one sequencer step.
module ledr_pattern_step
   import ledr_seq_pkg::*;
#(
   parameter int NUM_LEDS = 10
) (
   input  logic [NUM_LEDS-1:0] i_pattern,
   input  mode_t               i_mode,
   input  logic                i_dir,
   output logic [NUM_LEDS-1:0] o_pattern,
   output logic                o_dir
);
   always_comb begin
      o_pattern = i_pattern;
      o_dir     = i_dir;
      case (i_mode)
         ROTL:  o_pattern = {i_pattern[NUM_LEDS-2:0], i_pattern[NUM_LEDS-1]};
         COUNT: o_pattern = i_pattern + NUM_LEDS'(1);
         BLINK: o_pattern = ~i_pattern;
         BOUNCE: begin
            // reverse at an end bit; shifts zero-fill so an empty pattern stays empty
            if (i_dir == DIR_LEFT) begin
               o_pattern = i_pattern[NUM_LEDS-1] ? i_pattern >> 1 : i_pattern << 1;
               o_dir     = i_pattern[NUM_LEDS-1] ? DIR_RIGHT : DIR_LEFT;
            end else begin
               o_pattern = i_pattern[0] ? i_pattern << 1 : i_pattern >> 1;
               o_dir     = i_pattern[0] ? DIR_LEFT : DIR_RIGHT;
            end
         end
      endcase
   end
endmodule

// File: rtl/ledr_sequencer.sv
// ledr_sequencer: bus-mapped LEDR write-port driver; forwards CPU patterns or steps them
// autonomously at a programmable tick period.
module ledr_sequencer
   import ledr_seq_pkg::*;
#(
   parameter int NUM_LEDS       = 10,
   parameter int PERIOD_W       = 24,
   parameter int DEFAULT_PERIOD = 5_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  address,
   input  logic        write,
   input  logic        read,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        led_write,
   output logic [31:0] led_writedata
);
   state_t                r_state, w_state_nxt;
   mode_t                 r_mode;
   logic                  r_run, r_dir, r_led_write;
   logic [NUM_LEDS-1:0]   r_pattern, w_next_pattern;
   logic [PERIOD_W-1:0]   r_period, r_presc, w_last;
   logic [31:0]           r_readdata, r_led_wd, w_rd_mux;
   logic                  w_next_dir, w_wr_data, w_wr_ctrl, w_wr_period;
   logic                  w_run_on, w_run_off, w_tc, w_load, w_step, w_unused;

   assign w_wr_data   = write && address == ADDR_DATA;
   assign w_wr_ctrl   = write && address == ADDR_CTRL;
   assign w_wr_period = write && address == ADDR_PERIOD;
   assign w_run_on    = w_wr_ctrl && writedata[CTRL_RUN];
   assign w_run_off   = w_wr_ctrl && !writedata[CTRL_RUN];
   assign w_last      = (r_period == '0) ? '0 : r_period - PERIOD_W'(1);
   assign w_unused    = ^writedata[31:PERIOD_W];

   ledr_pattern_step #(.NUM_LEDS(NUM_LEDS)) u_step (
      .i_pattern (r_pattern),
      .i_mode    (r_mode),
      .i_dir     (r_dir),
      .o_pattern (w_next_pattern),
      .o_dir     (w_next_dir)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_tc        = r_state == RUN && r_presc == w_last;
      // a CPU pattern write or a stop request overrides the autonomous step
      w_step      = w_tc && !w_run_off && !w_wr_data;
      w_load      = r_state == LOAD && !w_run_off;
      if (w_run_off) w_state_nxt = IDLE;
      else if (r_state == IDLE && w_run_on) w_state_nxt = LOAD;
      else if (r_state == LOAD) w_state_nxt = RUN;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_state_nxt;

   assign w_rd_mux = (address == ADDR_DATA)   ? 32'(r_pattern) :
                     (address == ADDR_CTRL)   ? 32'({r_mode, r_run}) :
                     (address == ADDR_PERIOD) ? 32'(r_period) :
                                                32'({r_dir, r_state == RUN});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pattern   <= '0;
         r_mode      <= ROTL;
         r_run       <= 1'b0;
         r_dir       <= DIR_LEFT;
         r_presc     <= '0;
         r_period    <= PERIOD_W'(DEFAULT_PERIOD);
         r_led_write <= 1'b0;
         r_led_wd    <= '0;
         r_readdata  <= '0;
      end else begin
         r_led_write <= w_wr_data || w_load || w_step;
         if (w_wr_data) r_led_wd <= 32'(writedata[NUM_LEDS-1:0]);
         else if (w_load) r_led_wd <= 32'(r_pattern);
         else if (w_step) r_led_wd <= 32'(w_next_pattern);
         if (w_wr_data) r_pattern <= writedata[NUM_LEDS-1:0];
         else if (w_step) r_pattern <= w_next_pattern;
         if (w_load) r_dir <= DIR_LEFT;
         else if (w_step) r_dir <= w_next_dir;
         r_presc <= (r_state != RUN || w_wr_data || w_wr_period || w_tc) ? '0 : r_presc + PERIOD_W'(1);
         if (w_wr_ctrl) begin
            r_run  <= writedata[CTRL_RUN];
            r_mode <= mode_t'(writedata[CTRL_MODE_HI:CTRL_MODE_LO]);
         end
         if (w_wr_period) r_period <= writedata[PERIOD_W-1:0];
         if (read) r_readdata <= w_rd_mux;
      end
   end

   assign readdata      = r_readdata;
   assign led_write     = r_led_write;
   assign led_writedata = r_led_wd;
endmodule
